rom_port_arbiter: RTL and testbench
===================================

// Module: rom_port_arbiter
// PURPOSE
//  Shares the single combinational read port of the instruction ROM between two requesters:
//  instruction fetch (IF, default priority) and load unit (LS, read-only constants).
//  Grants at most one request per cycle, drives rom ce/addr, registers returned word.
//  Bounded IF run length guarantees LS forward progress. Sits between pipeline and rom.
// PARAMETERS
//  MAX_IF_RUN   4   max consecutive IF grants while LS is waiting (1..15)
//  ADDR_W  `ADDR_WIDTH  request address width; DATA_W  `DATA_WIDTH  word width
// PORTS
//  clk_i         in   1       clock, all state on rising edge
//  rst_n_i       in   1       asynchronous active-low reset
//  if_req_i      in   1       IF read request; hold req+addr stable until if_gnt_o
//  if_addr_i     in   ADDR_W  IF byte address
//  if_gnt_o      out  1       IF request accepted this cycle (combinational)
//  if_rvalid_o   out  1       IF response valid (one cycle after gnt)
//  if_rdata_o    out  DATA_W  IF response word
//  if_err_o      out  1       IF response is out-of-range (ROM_RANGE_CHK_EN only)
//  ls_req_i/ls_addr_i/ls_gnt_o/ls_rvalid_o/ls_rdata_o/ls_err_o   same, LS port
//  rom_ce_o      out  1       ROM chip enable
//  rom_addr_o    out  ADDR_W  ROM address (ROM word-aligns internally)
//  rom_inst_i    in   DATA_W  ROM combinational read data
// BEHAVIOUR
//  Reset: all gnt/rvalid/err 0, rdata 0, run counter 0, last-owner = IF.
//  Arbitration (combinational each cycle):
//   only one req -> grant it; both -> IF unless run_cnt == MAX_IF_RUN, then LS.
//   run_cnt: +1 on IF grant while ls_req_i high (saturate MAX_IF_RUN); clear on any LS grant
//   or on cycle with ls_req_i low.
//  Grant cycle: rom_ce_o=1, rom_addr_o=granted addr; no grant -> rom_ce_o=0, rom_addr_o=0.
//  Latency 1: rom_inst_i captured at granted edge; rvalid_o=1 for exactly one cycle next
//   cycle on the granted port only; rdata holds last value when rvalid=0.
//  Back-to-back: a port may be granted every cycle; rvalid streams every cycle.
//  Simultaneous rvalid on both ports never occurs (one grant per cycle).
//  Reset mid-transfer: pending response dropped, no rvalid after reset release.
//  Requester dropping req before gnt is legal; no state retained for it.
// CONFIGURATION
//  ROM_RANGE_CHK_EN defined: addr outside [`MEM_OFFSET, `MEM_OFFSET+`MEM_SIZE) is still
//   granted (consumes slot, counts in arbitration) but rom_ce_o=0; response rdata=0, err=1.
//  Not defined: no range check, address passed through, if_err_o/ls_err_o tied 0.
// STRUCTURE
//  defines.v: ADDR_WIDTH, DATA_WIDTH, MEM_OFFSET, MEM_SIZE (existing); add ARB_OWN_IF=1'b0,
//   ARB_OWN_LS=1'b1 encodings.
//  Sub-module rom_arb_resp: per-port rvalid/rdata/err register, instantiated twice.
// TESTING (MEM_OFFSET=0x8000_0000, MEM_SIZE=4096 in bench)
//  1 IF only, addr 0x8000_0004, ROM word 0x1234_5678 -> gnt same cycle, rvalid+rdata next.
//  2 IF and LS both held 10 cycles, MAX_IF_RUN=4 -> grant pattern IF,IF,IF,IF,LS repeating.
//  3 LS alone back-to-back 0x8000_0000..0x8000_000C -> 4 consecutive rvalids, correct words.
//  4 rst_n_i low in cycle after grant -> no rvalid, outputs 0 while low and after release.
//  5 ROM_RANGE_CHK_EN, IF addr 0x0000_0010 -> gnt, rom_ce_o=0, next cycle rdata 0, err 1.
//  6 Without macro, same stimulus -> rom_ce_o=1, err 0, data = ROM word at offset 0x10.

Source files
------------

// File: rtl/rom_port_arbiter_pkg.sv
// Shared types and constants for the ROM read-port arbiter.
// Memory-map and width defaults are provided here when the surrounding
// build does not already define them. The optional range check is
// enabled with the ROM_RANGE_CHK_EN macro (see rom_port_arbiter.sv).

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef MEM_OFFSET
`define MEM_OFFSET 32'h8000_0000
`endif
`ifndef MEM_SIZE
`define MEM_SIZE 4096
`endif
`ifndef ARB_OWN_IF
`define ARB_OWN_IF 1'b0
`endif
`ifndef ARB_OWN_LS
`define ARB_OWN_LS 1'b1
`endif

package rom_port_arbiter_pkg;

   localparam int ADDR_W = `ADDR_WIDTH;
   localparam int DATA_W = `DATA_WIDTH;

   // Width of the IF run-length counter; MAX_IF_RUN is limited to 1..15.
   localparam int RUN_W = 4;

   // ROM window [MEM_BASE, MEM_LIMIT), limit kept one bit wider so a window
   // ending exactly at the top of the address space does not wrap.
   localparam logic [ADDR_W-1:0] MEM_BASE  = `MEM_OFFSET;
   localparam logic [ADDR_W:0]   MEM_LIMIT = {1'b0, MEM_BASE} + (ADDR_W+1)'(`MEM_SIZE);

   // Which requester owns the response currently in flight.
   typedef enum logic {
      OWN_IF = `ARB_OWN_IF,
      OWN_LS = `ARB_OWN_LS
   } owner_e;

   // True when a byte address falls outside the ROM window.
   function automatic logic addr_out_of_range(input logic [ADDR_W-1:0] addr);
      logic [ADDR_W:0] addr_ext;
      addr_ext = {1'b0, addr};
      return (addr_ext < {1'b0, MEM_BASE}) || (addr_ext >= MEM_LIMIT);
   endfunction

endpackage

// File: rtl/rom_arb_resp.sv
// Per-requester response stage: holds the word (and error flag) captured
// on the cycle this port was granted, and presents it the following cycle.
// rdata keeps its last value between responses; err is only asserted
// alongside rvalid.

module rom_arb_resp
   import rom_port_arbiter_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              capture_i,   // this port is granted this cycle
   input  logic              pending_i,   // a response for this port is due now
   input  logic [DATA_W-1:0] data_i,      // ROM read data during the grant cycle
   input  logic              err_i,       // granted address was out of range
   output logic              rvalid_o,
   output logic [DATA_W-1:0] rdata_o,
   output logic              err_o
);

   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] rdata_d;
   logic              err_q;

   // Out-of-range accesses return zero instead of whatever the ROM drives.
   assign rdata_d = err_i ? '0 : data_i;

   // Capture the returned word on the granted edge; hold it otherwise.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else if (capture_i) begin
         rdata_q <= rdata_d;
         err_q   <= err_i;
      end
   end

   assign rvalid_o = pending_i;
   assign rdata_o  = rdata_q;
   assign err_o    = pending_i & err_q;

endmodule

// File: rtl/rom_port_arbiter.sv
// Two-requester arbiter for the single combinational ROM read port.
// Instruction fetch (IF) wins ties by default, but once it has been granted
// MAX_IF_RUN times in a row while the load unit (LS) waits, LS wins the next
// tie. Responses come back one cycle after the grant on the granted port.
// Optional feature: define ROM_RANGE_CHK_EN to flag addresses outside the
// ROM window (granted, ROM not enabled, response data 0 with err set).

module rom_port_arbiter
   import rom_port_arbiter_pkg::*;
#(
   parameter int unsigned MAX_IF_RUN = 4
) (
   input  logic              clk_i,
   input  logic              rst_n_i,

   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_gnt_o,
   output logic              if_rvalid_o,
   output logic [DATA_W-1:0] if_rdata_o,
   output logic              if_err_o,

   input  logic              ls_req_i,
   input  logic [ADDR_W-1:0] ls_addr_i,
   output logic              ls_gnt_o,
   output logic              ls_rvalid_o,
   output logic [DATA_W-1:0] ls_rdata_o,
   output logic              ls_err_o,

   output logic              rom_ce_o,
   output logic [ADDR_W-1:0] rom_addr_o,
   input  logic [DATA_W-1:0] rom_inst_i
);

   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_IF_RUN);

   logic [RUN_W-1:0]  run_cnt_q;
   logic [RUN_W-1:0]  run_cnt_d;
   logic              pend_q;
   logic              pend_d;
   owner_e            owner_q;
   owner_e            owner_d;

   logic              if_gnt;
   logic              ls_gnt;
   logic              gnt_any;
   logic [ADDR_W-1:0] gnt_addr;
   logic              gnt_oor;

   // Pick at most one requester: IF by default, LS when IF has used up its run.
   always_comb begin
      if_gnt = 1'b0;
      ls_gnt = 1'b0;
      if (if_req_i && ls_req_i) begin
         if (run_cnt_q == RUN_MAX) begin
            ls_gnt = 1'b1;
         end else begin
            if_gnt = 1'b1;
         end
      end else begin
         if_gnt = if_req_i;
         ls_gnt = ls_req_i;
      end
   end

   assign gnt_any  = if_gnt | ls_gnt;
   assign gnt_addr = ls_gnt ? ls_addr_i : if_addr_i;

`ifdef ROM_RANGE_CHK_EN
   assign gnt_oor = gnt_any & addr_out_of_range(gnt_addr);
`else
   assign gnt_oor = 1'b0;
`endif

   // Count IF wins that LS sat through; any LS win or idle LS resets the run.
   always_comb begin
      run_cnt_d = run_cnt_q;
      if (!ls_req_i || ls_gnt) begin
         run_cnt_d = '0;
      end else if (if_gnt && (run_cnt_q != RUN_MAX)) begin
         run_cnt_d = run_cnt_q + 1'b1;
      end
   end

   // Remember whether a response is due next cycle and which port owns it.
   always_comb begin
      pend_d  = gnt_any;
      owner_d = owner_q;
      if (ls_gnt) begin
         owner_d = OWN_LS;
      end else if (if_gnt) begin
         owner_d = OWN_IF;
      end
   end

   // Arbitration and response-tracking state; reset drops any pending response.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         run_cnt_q <= '0;
         pend_q    <= 1'b0;
         owner_q   <= OWN_IF;
      end else begin
         run_cnt_q <= run_cnt_d;
         pend_q    <= pend_d;
         owner_q   <= owner_d;
      end
   end

   // ROM is only enabled for an in-range grant; address is zero when idle.
   assign rom_ce_o   = gnt_any & ~gnt_oor;
   assign rom_addr_o = gnt_any ? gnt_addr : '0;

   assign if_gnt_o = if_gnt;
   assign ls_gnt_o = ls_gnt;

   rom_arb_resp u_if_resp (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .capture_i (if_gnt),
      .pending_i (pend_q && (owner_q == OWN_IF)),
      .data_i    (rom_inst_i),
      .err_i     (gnt_oor),
      .rvalid_o  (if_rvalid_o),
      .rdata_o   (if_rdata_o),
      .err_o     (if_err_o)
   );

   rom_arb_resp u_ls_resp (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .capture_i (ls_gnt),
      .pending_i (pend_q && (owner_q == OWN_LS)),
      .data_i    (rom_inst_i),
      .err_i     (gnt_oor),
      .rvalid_o  (ls_rvalid_o),
      .rdata_o   (ls_rdata_o),
      .err_o     (ls_err_o)
   );

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Scoreboard bench for rom_port_arbiter: the stimulus process predicts each
// cycle's grant and each response from a simple reference model and queues
// them; a negedge monitor compares DUT outputs against the queues.
// Range-check expectations follow the ROM_RANGE_CHK_EN macro.

module tb_rom_port_arbiter;

   localparam int MAXRUN = 4;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_req = 1'b0;
   logic        ls_req = 1'b0;
   logic [31:0] if_addr = 32'd0;
   logic [31:0] ls_addr = 32'd0;
   logic        if_gnt, if_rvalid, if_err;
   logic        ls_gnt, ls_rvalid, ls_err;
   logic [31:0] if_rdata, ls_rdata;
   logic        rom_ce;
   logic [31:0] rom_addr;
   logic [31:0] rom_inst;

   logic [31:0] rom_mem [1024];

   // Behavioural ROM: word-aligned lookup, garbage when not enabled.
   assign rom_inst = rom_ce ? rom_mem[rom_addr[11:2]] : 32'hDEAD_BEEF;

   rom_port_arbiter #(.MAX_IF_RUN(MAXRUN)) dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .if_req_i    (if_req),
      .if_addr_i   (if_addr),
      .if_gnt_o    (if_gnt),
      .if_rvalid_o (if_rvalid),
      .if_rdata_o  (if_rdata),
      .if_err_o    (if_err),
      .ls_req_i    (ls_req),
      .ls_addr_i   (ls_addr),
      .ls_gnt_o    (ls_gnt),
      .ls_rvalid_o (ls_rvalid),
      .ls_rdata_o  (ls_rdata),
      .ls_err_o    (ls_err),
      .rom_ce_o    (rom_ce),
      .rom_addr_o  (rom_addr),
      .rom_inst_i  (rom_inst)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      logic [34:0] v;      // {if_gnt, ls_gnt, rom_ce, rom_addr}
   } gexp_t;

   typedef struct {
      int          due;
      logic [31:0] data;
      logic        err;
   } rexp_t;

   gexp_t       gq[$];
   rexp_t       ifq[$];
   rexp_t       lsq[$];
   logic [31:0] if_last = 32'd0;
   logic [31:0] ls_last = 32'd0;
   int          wait_cnt = 0;
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic logic out_of_range(input logic [31:0] a);
`ifdef ROM_RANGE_CHK_EN
      return (a < 32'h8000_0000) || (a >= 32'h8000_1000);
`else
      return 1'b0;
`endif
   endfunction

   // Monitor: compare grant/ROM signals and both response ports every cycle.
   always @(negedge clk) begin
      logic        v;
      logic        e;
      logic [31:0] d;
      if (gq.size() > 0 && gq[0].cyc == cyc) begin
         check("grant", {29'd0, if_gnt, ls_gnt, rom_ce, rom_addr}, {29'd0, gq[0].v});
         void'(gq.pop_front());
      end
      v = 1'b0; e = 1'b0; d = if_last;
      if (ifq.size() > 0 && ifq[0].due == cyc) begin
         v = 1'b1; e = ifq[0].err; d = ifq[0].data;
         if_last = d;
         void'(ifq.pop_front());
      end
      check("if_resp", {30'd0, if_rvalid, if_err, if_rdata}, {30'd0, v, e, d});
      v = 1'b0; e = 1'b0; d = ls_last;
      if (lsq.size() > 0 && lsq[0].due == cyc) begin
         v = 1'b1; e = lsq[0].err; d = lsq[0].data;
         ls_last = d;
         void'(lsq.pop_front());
      end
      check("ls_resp", {30'd0, ls_rvalid, ls_err, ls_rdata}, {30'd0, v, e, d});
   end

   // One active cycle: drive inputs, predict grant and response, advance clock.
   task automatic step(input logic ir, input logic [31:0] ia,
                       input logic lr, input logic [31:0] la,
                       output logic ig, output logic lg);
      logic [31:0] ga;
      logic        oor;
      logic        ce;
      rexp_t       r;
      rst_n = 1'b1;
      if_req = ir; if_addr = ia;
      ls_req = lr; ls_addr = la;
      ig = 1'b0; lg = 1'b0;
      if (ir && lr) begin
         if (wait_cnt >= MAXRUN) lg = 1'b1;
         else                    ig = 1'b1;
      end else begin
         ig = ir;
         lg = lr;
      end
      if (!lr || lg)  wait_cnt = 0;
      else if (ig)    wait_cnt = (wait_cnt + 1 > MAXRUN) ? MAXRUN : wait_cnt + 1;
      ga  = lg ? la : (ig ? ia : 32'd0);
      oor = (ig || lg) && out_of_range(ga);
      ce  = (ig || lg) && !oor;
      gq.push_back('{cyc, {ig, lg, ce, ga}});
      if (ig || lg) begin
         r.due  = cyc + 1;
         r.err  = oor;
         r.data = oor ? 32'd0 : rom_mem[ga[11:2]];
         if (ig) ifq.push_back(r);
         else    lsq.push_back(r);
      end
      @(posedge clk); #1;
   endtask

   // Hold reset for n cycles with requests idle; pending responses are dropped.
   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) begin
         rst_n = 1'b0;
         if_req = 1'b0; ls_req = 1'b0;
         if_addr = 32'd0; ls_addr = 32'd0;
         ifq.delete(); lsq.delete();
         if_last = 32'd0; ls_last = 32'd0;
         wait_cnt = 0;
         gq.push_back('{cyc, 35'd0});
         @(posedge clk); #1;
      end
   endtask

   function automatic logic [31:0] rand_addr();
      case ($urandom_range(0, 7))
         0:       return $urandom & 32'h7FFF_FFFC;
         1:       return 32'h8000_1000 + ($urandom_range(0, 255) << 2);
         default: return 32'h8000_0000 + ($urandom_range(0, 1023) << 2);
      endcase
   endfunction

   initial begin
      logic        ig, lg;
      logic        ip, lp;
      logic [31:0] ia, la;
      for (int i = 0; i < 1024; i++) rom_mem[i] = $urandom;
      rom_mem[1] = 32'h1234_5678;

      do_reset(3);

      // IF alone: grant same cycle, data next cycle.
      step(1'b1, 32'h8000_0004, 1'b0, 32'd0, ig, lg);
      step(1'b0, 32'd0, 1'b0, 32'd0, ig, lg);

      // Both requesting continuously: IF run limited, LS gets every fifth slot.
      ia = 32'h8000_0100; la = 32'h8000_0200;
      for (int i = 0; i < 10; i++) begin
         step(1'b1, ia, 1'b1, la, ig, lg);
         if (ig) ia = ia + 32'd4;
         if (lg) la = la + 32'd4;
      end
      step(1'b0, 32'd0, 1'b0, 32'd0, ig, lg);

      // LS back-to-back streaming.
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 32'd0, 1'b1, 32'h8000_0000 + 32'(i * 4), ig, lg);
      end
      step(1'b0, 32'd0, 1'b0, 32'd0, ig, lg);

      // Reset in the cycle after a grant drops the response.
      step(1'b1, 32'h8000_0008, 1'b0, 32'd0, ig, lg);
      do_reset(2);
      step(1'b0, 32'd0, 1'b0, 32'd0, ig, lg);
      step(1'b0, 32'd0, 1'b0, 32'd0, ig, lg);

      // Address below the ROM window.
      step(1'b1, 32'h0000_0010, 1'b0, 32'd0, ig, lg);
      step(1'b0, 32'd0, 1'b0, 32'd0, ig, lg);

      // Randomized traffic with an embedded reset.
      ip = 1'b0; lp = 1'b0; ia = 32'd0; la = 32'd0;
      for (int i = 0; i < 400; i++) begin
         if (i == 200) begin
            do_reset(2);
            ip = 1'b0; lp = 1'b0;
         end
         if (!ip && ($urandom_range(0, 3) != 0)) begin ip = 1'b1; ia = rand_addr(); end
         if (!lp && ($urandom_range(0, 2) == 0)) begin lp = 1'b1; la = rand_addr(); end
         step(ip, ia, lp, la, ig, lg);
         if (ig) ip = 1'b0;
         else if (ip && ($urandom_range(0, 15) == 0)) ip = 1'b0;
         if (lg) lp = 1'b0;
         else if (lp && ($urandom_range(0, 15) == 0)) lp = 1'b0;
      end

      step(1'b0, 32'd0, 1'b0, 32'd0, ig, lg);
      step(1'b0, 32'd0, 1'b0, 32'd0, ig, lg);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
